// File: rtl/mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul8_seq_ctrl (with helper mul4x4_array)
// Purpose  : Unsigned 8x8 -> 16 multiplier built by sequencing one 4x4 array
//            multiplier over up to four nibble-pair steps, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================

module mul4x4_array (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [7:0] w_row [4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_row
            assign w_row[i] = {4'b0000, x & {4{y[i]}}} << i;
        end
    endgenerate

    assign p = w_row[0] + w_row[1] + w_row[2] + w_row[3];
endmodule

module mul8_seq_ctrl #(
    parameter int SKIP_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_result;
    logic        r_out_valid;
    logic [3:0]  r_mask;

    logic [3:0]  w_nib_nz;
    logic [3:0]  w_mask_in;
    logic [3:0]  w_low;
    logic [3:0]  w_mask_nxt;
    logic [3:0]  w_x;
    logic [3:0]  w_y;
    logic [3:0]  w_shift;
    logic [7:0]  w_pp;
    logic [15:0] w_addend;
    logic [15:0] w_sum;

    // Bit k set when both nibbles feeding step k are nonzero
    assign w_nib_nz = {(|a[7:4]) & (|b[7:4]),
                       (|a[3:0]) & (|b[7:4]),
                       (|a[7:4]) & (|b[3:0]),
                       (|a[3:0]) & (|b[3:0])};

    generate
        if (SKIP_ZERO != 0) begin : g_skip
            assign w_mask_in = w_nib_nz;
        end else begin : g_all
            assign w_mask_in = 4'b1111;
        end
    endgenerate

    assign w_low      = r_mask & (~r_mask + 4'd1);
    assign w_mask_nxt = r_mask & ~w_low;

    always_comb begin
        w_x     = r_a[3:0];
        w_y     = r_b[3:0];
        w_shift = 4'd0;
        if (w_low[1]) begin
            w_x     = r_a[7:4];
            w_shift = 4'd4;
        end else if (w_low[2]) begin
            w_y     = r_b[7:4];
            w_shift = 4'd4;
        end else if (w_low[3]) begin
            w_x     = r_a[7:4];
            w_y     = r_b[7:4];
            w_shift = 4'd8;
        end
    end

    mul4x4_array u_mul (
        .x (w_x),
        .y (w_y),
        .p (w_pp)
    );

    // An empty mask is the one-cycle no-op pass: nothing is added
    assign w_addend = (r_mask == 4'd0) ? 16'h0000 : ({8'h00, w_pp} << w_shift);
    assign w_sum    = r_acc + w_addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= 8'h00;
            r_b         <= 8'h00;
            r_acc       <= 16'h0000;
            r_result    <= 16'h0000;
            r_out_valid <= 1'b0;
            r_mask      <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= 16'h0000;
                        r_mask  <= w_mask_in;
                        r_state <= c_MUL;
                    end
                end
                c_MUL: begin
                    r_acc  <= w_sum;
                    r_mask <= w_mask_nxt;
                    if (w_mask_nxt == 4'd0) begin
                        r_result    <= w_sum;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
endmodule

`default_nettype wire

// File: tb/tb_mul8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul8_seq_ctrl
// Purpose  : Directed bench for both SKIP_ZERO settings against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mul8_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv0 = 1'b0, iv1 = 1'b0, ordy0 = 1'b0, ordy1 = 1'b0;
    logic [7:0]  a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;
    logic        ir0, ir1, ov0, ov1, bz0, bz1;
    logic [15:0] res0, res1;

    int n_cmp = 0;
    int n_bad = 0;
    int xfer1 = 0;
    int acc1  = 0;

    always #5 clk = ~clk;

    mul8_seq_ctrl #(.SKIP_ZERO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .out_valid(ov0), .out_ready(ordy0), .result(res0), .busy(bz0));

    mul8_seq_ctrl #(.SKIP_ZERO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(ordy1), .result(res1), .busy(bz1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Latency straight from the rules: 4 always, or popcount of nonzero nibble pairs (min 1)
    function automatic int f_lat(input logic [7:0] x, input logic [7:0] y, input bit skip);
        int n;
        if (!skip) return 4;
        n = 0;
        if (x[3:0] != 0 && y[3:0] != 0) n++;
        if (x[7:4] != 0 && y[3:0] != 0) n++;
        if (x[3:0] != 0 && y[7:4] != 0) n++;
        if (x[7:4] != 0 && y[7:4] != 0) n++;
        return (n == 0) ? 1 : n;
    endfunction

    bit          m_pend [2] = '{0, 0};
    bit          m_ov   [2] = '{0, 0};
    int          m_cnt  [2] = '{0, 0};
    logic [15:0] m_prod [2] = '{16'h0, 16'h0};
    logic [15:0] m_res  [2] = '{16'h0, 16'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 0; m_ov[i] = 0; m_cnt[i] = 0; m_res[i] = 16'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic       v, r;
                logic [7:0] x, y;
                v = (i == 1) ? iv1 : iv0;
                r = (i == 1) ? ordy1 : ordy0;
                x = (i == 1) ? a1 : a0;
                y = (i == 1) ? b1 : b0;
                if (m_ov[i]) begin
                    if (r) m_ov[i] = 0;
                end else if (m_pend[i]) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_pend[i] = 0;
                        m_ov[i]   = 1;
                        m_res[i]  = m_prod[i];
                    end
                end else if (v) begin
                    m_pend[i] = 1;
                    m_prod[i] = 16'(x) * 16'(y);
                    m_cnt[i]  = f_lat(x, y, i == 1);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (ov1 && ordy1) xfer1++;
            if (ir1 && iv1)   acc1++;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit idle;
            idle = !m_pend[i] && !m_ov[i];
            chk($sformatf("cyc%0d_in_ready", i), 32'((i == 1) ? ir1 : ir0), 32'(idle));
            chk($sformatf("cyc%0d_busy", i), 32'((i == 1) ? bz1 : bz0), 32'(!idle));
            chk($sformatf("cyc%0d_out_valid", i), 32'((i == 1) ? ov1 : ov0), 32'(m_ov[i]));
            chk($sformatf("cyc%0d_result", i), 32'((i == 1) ? res1 : res0), 32'(m_res[i]));
        end
    end

    task automatic drive(input int s, input logic v, input logic [7:0] x, input logic [7:0] y);
        if (s == 1) begin iv1 = v; a1 = x; b1 = y; end
        else        begin iv0 = v; a0 = x; b0 = y; end
    endtask

    task automatic set_rdy(input int s, input logic v);
        if (s == 1) ordy1 = v; else ordy0 = v;
    endtask

    task automatic run_op(input int s, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp_res, input int exp_lat, input bit rel);
        int lat;
        @(negedge clk);
        chk($sformatf("op%0d_%h_%h_ready", s, x, y), 32'((s == 1) ? ir1 : ir0), 32'd1);
        drive(s, 1'b1, x, y);
        @(posedge clk);
        #1;
        drive(s, 1'b0, 8'h00, 8'h00);
        chk($sformatf("op%0d_%h_%h_busy", s, x, y), 32'((s == 1) ? bz1 : bz0), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!((s == 1) ? ov1 : ov0) && lat < 20);
        chk($sformatf("op%0d_%h_%h_latency", s, x, y), 32'(lat), 32'(exp_lat));
        chk($sformatf("op%0d_%h_%h_result", s, x, y), 32'((s == 1) ? res1 : res0), 32'(exp_res));
        if (rel) begin
            @(negedge clk);
            set_rdy(s, 1'b1);
            @(posedge clk);
            #1;
            set_rdy(s, 1'b0);
            chk($sformatf("op%0d_%h_%h_ov_drop", s, x, y), 32'((s == 1) ? ov1 : ov0), 32'd0);
        end
    endtask

    initial begin
        int x0, a0c;
        rst_n = 1'b0;
        #1;
        chk("reset_in_ready", 32'(ir1), 32'd1);
        chk("reset_out_valid", 32'(ov1), 32'd0);
        chk("reset_busy", 32'(bz0), 32'd0);
        chk("reset_result", 32'(res0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 8'h12, 8'h34, 16'h03A8, 4, 1);
        run_op(0, 8'hFF, 8'hFF, 16'hFE01, 4, 1);
        run_op(1, 8'hFF, 8'hFF, 16'hFE01, 4, 1);
        run_op(1, 8'h05, 8'h07, 16'h0023, 1, 1);
        run_op(1, 8'h10, 8'h10, 16'h0100, 1, 1);
        run_op(1, 8'h00, 8'hAB, 16'h0000, 1, 1);
        run_op(1, 8'h0F, 8'hF0, 16'h0E10, 1, 1);

        // Back-pressure: result held while new operands are offered
        run_op(1, 8'h21, 8'h03, 16'h0063, 2, 0);
        x0  = xfer1;
        a0c = acc1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(ov1), 32'd1);
            chk("bp_result", 32'(res1), 32'h0063);
            chk("bp_in_ready", 32'(ir1), 32'd0);
            drive(1, (k % 2 == 0), 8'(8'h31 + k), 8'(8'h17 + k));
        end
        @(negedge clk);
        drive(1, 1'b0, 8'h00, 8'h00);
        set_rdy(1, 1'b1);
        @(negedge clk);
        set_rdy(1, 1'b0);
        @(negedge clk);
        chk("bp_transfers", 32'(xfer1 - x0), 32'd1);
        chk("bp_accepts", 32'(acc1 - a0c), 32'd0);

        // Asynchronous reset while step 2 is in progress
        @(negedge clk);
        drive(1, 1'b1, 8'hAB, 8'hCD);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov1), 32'd0);
        chk("midrst_result", 32'(res1), 32'd0);
        chk("midrst_busy", 32'(bz1), 32'd0);
        chk("midrst_in_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 8'h03, 8'h04, 16'h000C, 1, 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
